// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus for the sequential divider.
// The master side issues operands; the slave side is the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             err;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, quotient, remainder, err
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, quotient, remainder, err
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned per
// operation; divide-by-zero skips the iteration and raises err.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   bmag;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] amag_in;
  logic [WIDTH-1:0] bmag_in;

  always_comb begin
    shifted = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    diff    = shifted - bmag;
    qbit    = (shifted >= bmag);
    sa      = bus.signed_mode & bus.a[WIDTH-1];
    sb      = bus.signed_mode & bus.b[WIDTH-1];
    // Most-negative operand negates to itself, which is the correct unsigned magnitude.
    amag_in = sa ? -bus.a : bus.a;
    bmag_in = sb ? -bus.b : bus.b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dvd           <= '0;
      prem          <= '0;
      bmag          <= '0;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div0          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dvd      <= amag_in;
            bmag     <= {1'b0, bmag_in};
            prem     <= '0;
            cnt      <= CW'(WIDTH);
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            div0     <= (bus.b == '0);
            bus.busy <= 1'b1;
            state    <= (bus.b == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          // Dividend bits shift out the top while quotient bits fill from the bottom.
          prem <= qbit ? diff : shifted;
          dvd  <= {dvd[WIDTH-2:0], qbit};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          bus.quotient  <= neg_q ? -dvd : dvd;
          bus.remainder <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          state         <= S_DONE;
        end
        S_DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.err  <= div0;
          if (div0) begin
            bus.quotient  <= '0;
            bus.remainder <= '0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle radix-2 restoring divider with a start/done handshake. It produces one quotient bit per clock and supports both unsigned and signed (two's-complement) operation, selected per operation. Divide-by-zero is flagged rather than computed. The block is the clocked, parametrised successor to the team's combinational divider and is intended for datapaths where a WIDTH-deep adder chain cannot meet timing.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only when busy=0
signed_mode  input  1  0 = unsigned, 1 = signed two's-complement; sampled with start
a  input  WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
busy  output  1  high from the edge after accept until the edge that raises done
done  output  1  single-cycle pulse; results valid in this cycle and held afterwards
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
err  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, err=0. All internal registers are cleared. Reset overrides an operation in progress and any simultaneous start; that operation produces no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start=1, latch a, b and signed_mode.
  - If b==0: go to DONE.
  - Otherwise: compute magnitudes |a| and |b| (the magnitude equals the raw value when unsigned), record neg_q = sign(a)^sign(b) and neg_r = sign(a) (both are 0 when unsigned), load the iteration counter with WIDTH, and go to CALC.
  - busy=1 from the next cycle.
- CALC: one restoring step per clock on a (WIDTH+1)-bit partial remainder P:
  - P' = {P[WIDTH-1:0], next dividend MSB}.
  - If P' >= |b|: P = P' - |b| and the quotient bit is 1; else P = P' and the quotient bit is 0.
  - The quotient register shifts left with the new bit.
  - The counter decrements each clock; after exactly WIDTH CALC cycles, go to FIX.
- FIX (1 clock):
  - quotient = neg_q ? -Q : Q; remainder = neg_r ? -P : P (truncated to WIDTH bits).
  - Go to DONE.
- DONE (1 clock): done=1, busy=0; return to IDLE.
  - Divide-by-zero path: quotient=0, remainder=0, err=1.
  - Normal path: err=0.
- Latency, with the start accept edge counted as edge 0:
  - Normal: done high in the cycle after edge WIDTH+2, so the first done cycle begins WIDTH+2 clocks after the accept edge.
  - Divide-by-zero: done high in the cycle after edge 1.
  - Throughput: a new start can be accepted in the DONE cycle's following IDLE cycle; start during DONE is ignored.
- start while busy=1 or during DONE: ignored, with no effect on operands or state.
- Outputs hold their last values until the next FIX/DONE update; done is never high for two consecutive cycles.
- Signed semantics:
  - Quotient truncates toward zero; a nonzero remainder takes the sign of the dividend; identity a = q*b + r holds mod 2^WIDTH.
  - Overflow case: most-negative / -1 gives quotient = most-negative (wrap), remainder=0, err=0.
- Unsigned a<b: quotient=0, remainder=a. a==0: quotient=0, remainder=0 (full latency still applies).
- All arithmetic is internal WIDTH+1 bits; no state depends on X from uninitialised registers after reset.

Test Plan:
- WIDTH=8, unsigned, a=100, b=7, start for 1 cycle -> busy high for the compute period, done after 10 clocks, quotient=14, remainder=2, err=0.
- Unsigned a=255, b=1 -> quotient=255, remainder=0. Unsigned a=3, b=10 -> quotient=0, remainder=3.
- a=5, b=0 (either mode) -> done 1 clock after the done-setup edge (fast path), quotient=0, remainder=0, err=1. The next valid operation clears err to 0.
- Signed a=0xF9 (-7), b=2 -> quotient=0xFD (-3), remainder=0xFF (-1). Signed a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, err=0.
- Assert start again 3 cycles into a 100/7 operation with a=9, b=3 -> ignored; result is still 14 r 2, with exactly one done pulse.
- Pull rst_n low for one edge mid-CALC -> next cycle busy=0, done=0, outputs=0, and no done is ever issued for that operation. Then 50/5 gives quotient=10, remainder=0.
